pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, cycles flush_IF/flush_ID stay asserted per taken branch (legal 1..7).
REQ-002 Parameter: STALL_CNT_W, 32, width of stall_count.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  ID holds a valid instruction.
REQ-006 rs1_ID, rs2_ID  in  4  source registers in ID.
REQ-007 rs1_used_ID, rs2_used_ID  in  1  ID instruction reads rs1 / rs2.
REQ-008 rd_ID  in  4  destination register in ID.
REQ-009 regfile_we_ID, is_load_ID  in  1  ID writes rd; ID is a load.
REQ-010 regfile_we_EX  in  1  EX writes rd.
REQ-011 rd_EX  in  4  EX destination register.
REQ-012 rd_data_sel_EX  in  2  EX result source, `RD_DATA_SEL_* encoding.
REQ-013 branch_taken_EX  in  1  EX resolved a taken branch or jump.
REQ-014 mem_req_MEMEX, mem_ready  in  1  MEMEX bus request; bus completion.
REQ-015 load_wb_valid  in  1  load data written to regfile this cycle.
REQ-016 load_wb_rd  in  4  register written by that load.
REQ-017 stall_IF, stall_ID  out  1  hold IF / ID registers.
REQ-018 bubble_EX  out  1  insert NOP into EX.
REQ-019 stall_back  out  1  hold EX, MEMPREP, MEMEX registers.
REQ-020 bubble_WB  out  1  insert NOP into WB.
REQ-021 flush_IF, flush_ID  out  1  squash IF / ID contents.
REQ-022 scoreboard  out  16  bit n set = load to xn in flight.
REQ-023 stall_count  out  STALL_CNT_W  cycles with stall_ID=1.

Function
REQ-024 FSM states: RUN, MEM_WAIT, FLUSH; encoded state register, next-state logic combinational.
REQ-025 Priority each cycle: MEM_WAIT condition > branch flush > data hazard.
REQ-026 RUN -> MEM_WAIT when mem_req_MEMEX=1 and mem_ready=0; MEM_WAIT -> RUN in the cycle after mem_ready=1.
REQ-027 While mem_req_MEMEX & !mem_ready (RUN or MEM_WAIT): stall_IF=stall_ID=stall_back=bubble_WB=1, bubble_EX=0, flush_*=0; branch_taken_EX ignored (EX frozen, re-presented after exit).
REQ-028 In RUN, branch_taken_EX=1 (no mem wait): flush_IF=flush_ID=1 same cycle; if FLUSH_CYCLES>1 go to FLUSH, else stay RUN.
REQ-029 FLUSH holds flush_IF=flush_ID=1 for FLUSH_CYCLES-1 cycles (3-bit down-counter), then RUN; mem-wait condition in FLUSH preempts to MEM_WAIT with counter held, resuming FLUSH afterwards.
REQ-030 hazard = id_valid & ((rs1_used_ID & rs1_ID!=0 & dep(rs1_ID)) | same for rs2), dep(r) = scoreboard[r] | (regfile_we_EX & rd_EX==r & rd_data_sel_EX!=`RD_DATA_SEL_ALU).
REQ-031 In RUN with hazard and no flush/mem wait: stall_IF=stall_ID=bubble_EX=1, others 0; zero added latency beyond dependency resolution.
REQ-032 Flush overrides hazard: while flush_ID=1, stall_ID=0.
REQ-033 Scoreboard set of bit rd_ID when id_valid & regfile_we_ID & is_load_ID & rd_ID!=0 & !stall_ID & !flush_ID.
REQ-034 Scoreboard clear of bit load_wb_rd when load_wb_valid; simultaneous set and clear of same bit: set wins.
REQ-035 scoreboard[0] always 0.
REQ-036 stall_count increments by 1 each cycle stall_ID=1; saturates at all-ones.
REQ-037 All outputs 0 when no condition active.

Reset
REQ-038 rst_n=0 asynchronously forces state=RUN, flush counter=0, scoreboard=0, stall_count=0; combinational outputs follow from these values and inputs.
REQ-039 Reset mid-MEM_WAIT or mid-FLUSH abandons operation; first cycle after release behaves as RUN.

Verification
REQ-040 Load to x5 issued, next ID reads x5 -> scoreboard=0x0020, stall_ID=bubble_EX=1 until load_wb_valid/rd=5, released the cycle after.
REQ-041 JAL in EX writing x1 (sel=PC4), ID reads x1 -> 1-cycle stall; same with sel=ALU -> no stall.
REQ-042 branch_taken_EX pulse, FLUSH_CYCLES=2 -> flush_IF/ID high exactly 2 cycles; FLUSH_CYCLES=1 -> 1 cycle.
REQ-043 mem_req_MEMEX held with mem_ready low 3 cycles while branch_taken_EX=1 -> stall_back high 3 cycles, no flush; flush follows after mem_ready.
REQ-044 load_wb clear and new load set on x7 same cycle -> scoreboard[7]=1; ID reads x0 with scoreboard busy -> no stall.
REQ-045 rst_n low during MEM_WAIT with scoreboard=0x00F0, stall_count=9 -> all zero immediately, RUN after release.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-unit signal bundle between the pipeline datapath (master) and the
// hazard controller (slave).
`ifndef RD_DATA_SEL_ALU
`define RD_DATA_SEL_ALU 2'd0
`endif
`ifndef RD_DATA_SEL_MEM
`define RD_DATA_SEL_MEM 2'd1
`endif
`ifndef RD_DATA_SEL_PC4
`define RD_DATA_SEL_PC4 2'd2
`endif
`ifndef RD_DATA_SEL_CSR
`define RD_DATA_SEL_CSR 2'd3
`endif

interface pipeline_hazard_controller_if #(
    parameter int STALL_CNT_W = 32
);
    logic                   id_valid;
    logic [3:0]             rs1_ID;
    logic [3:0]             rs2_ID;
    logic                   rs1_used_ID;
    logic                   rs2_used_ID;
    logic [3:0]             rd_ID;
    logic                   regfile_we_ID;
    logic                   is_load_ID;
    logic                   regfile_we_EX;
    logic [3:0]             rd_EX;
    logic [1:0]             rd_data_sel_EX;
    logic                   branch_taken_EX;
    logic                   mem_req_MEMEX;
    logic                   mem_ready;
    logic                   load_wb_valid;
    logic [3:0]             load_wb_rd;
    logic                   stall_IF;
    logic                   stall_ID;
    logic                   bubble_EX;
    logic                   stall_back;
    logic                   bubble_WB;
    logic                   flush_IF;
    logic                   flush_ID;
    logic [15:0]            scoreboard;
    logic [STALL_CNT_W-1:0] stall_count;

    // Level-based control, no valid/ready pairing: every output is a pure
    // function of current inputs and controller state, updated each cycle.
    modport master (
        output id_valid, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_ID,
               regfile_we_ID, is_load_ID, regfile_we_EX, rd_EX, rd_data_sel_EX,
               branch_taken_EX, mem_req_MEMEX, mem_ready, load_wb_valid, load_wb_rd,
        input  stall_IF, stall_ID, bubble_EX, stall_back, bubble_WB,
               flush_IF, flush_ID, scoreboard, stall_count
    );

    modport slave (
        input  id_valid, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID, rd_ID,
               regfile_we_ID, is_load_ID, regfile_we_EX, rd_EX, rd_data_sel_EX,
               branch_taken_EX, mem_req_MEMEX, mem_ready, load_wb_valid, load_wb_rd,
        output stall_IF, stall_ID, bubble_EX, stall_back, bubble_WB,
               flush_IF, flush_ID, scoreboard, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: memory-wait stalls, branch flush sequencing and
// load-use / non-forwardable-EX data hazard interlock with a load scoreboard.
module pipeline_hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_controller_if.slave   bus,
    output logic [1:0]                    state_dbg_o
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [2:0]             flush_cnt_q, flush_cnt_d;
    logic [15:0]            sb_q, sb_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_wait;
    logic flush_pending;
    logic ex_no_fwd;
    logic dep1, dep2, hazard;
    logic stall_if, stall_id, bubble_ex, stall_back, bubble_wb, flush;
    logic sb_set;

    assign mem_wait      = bus.mem_req_MEMEX & ~bus.mem_ready;
    // A flush interrupted by a memory wait keeps its count and resumes here.
    assign flush_pending = (state_q != RUN) & (flush_cnt_q != 3'd0);
    // Only ALU results can be forwarded out of EX; anything else must wait.
    assign ex_no_fwd     = bus.regfile_we_EX & (bus.rd_data_sel_EX != `RD_DATA_SEL_ALU);

    assign dep1   = sb_q[bus.rs1_ID] | (ex_no_fwd & (bus.rd_EX == bus.rs1_ID));
    assign dep2   = sb_q[bus.rs2_ID] | (ex_no_fwd & (bus.rd_EX == bus.rs2_ID));
    assign hazard = bus.id_valid &
                    ((bus.rs1_used_ID & (bus.rs1_ID != 4'd0) & dep1) |
                     (bus.rs2_used_ID & (bus.rs2_ID != 4'd0) & dep2));

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        stall_back  = 1'b0;
        bubble_wb   = 1'b0;
        flush       = 1'b0;
        if (mem_wait) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_back = 1'b1;
            bubble_wb  = 1'b1;
            state_d    = MEM_WAIT;
        end else if (flush_pending) begin
            flush       = 1'b1;
            flush_cnt_d = flush_cnt_q - 3'd1;
            state_d     = (flush_cnt_q == 3'd1) ? RUN : FLUSH;
        end else begin
            state_d = RUN;
            if (bus.branch_taken_EX) begin
                flush       = 1'b1;
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = (FLUSH_RELOAD != 3'd0) ? FLUSH : RUN;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    assign sb_set = bus.id_valid & bus.regfile_we_ID & bus.is_load_ID &
                    (bus.rd_ID != 4'd0) & ~stall_id & ~flush;

    always_comb begin
        sb_d = sb_q;
        if (bus.load_wb_valid) sb_d[bus.load_wb_rd] = 1'b0;
        if (sb_set)            sb_d[bus.rd_ID]      = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_id && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            sb_q        <= 16'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_IF    = stall_if;
    assign bus.stall_ID    = stall_id;
    assign bus.bubble_EX   = bubble_ex;
    assign bus.stall_back  = stall_back;
    assign bus.bubble_WB   = bubble_wb;
    assign bus.flush_IF    = flush;
    assign bus.flush_ID    = flush;
    assign bus.scoreboard  = sb_q;
    assign bus.stall_count = stall_cnt_q;
    assign state_dbg_o     = state_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: reference model feeds an expected
// queue each cycle; directed scenarios plus a random phase.
module tb_pipeline_hazard_controller;
  localparam int         FC0    = 2;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_MW   = 2'd1;
  localparam logic [1:0] S_FL   = 2'd2;
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.STALL_CNT_W(32)) if0 ();
  pipeline_hazard_controller_if #(.STALL_CNT_W(32)) if1 ();
  logic [1:0] st0, st1;

  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .STALL_CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .state_dbg_o(st0));
  pipeline_hazard_controller #(.FLUSH_CYCLES(1), .STALL_CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .state_dbg_o(st1));

  logic [63:0] obs_ctl, obs_cnt;
  assign obs_ctl = {39'd0, st0, if0.stall_IF, if0.stall_ID, if0.bubble_EX, if0.stall_back,
                    if0.bubble_WB, if0.flush_IF, if0.flush_ID, if0.scoreboard};
  assign obs_cnt = {32'd0, if0.stall_count};

  // scoreboard / model state
  logic [63:0] exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] m_sb;
  int          m_left;
  logic [1:0]  m_st;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_dep(input logic [3:0] r);
    return m_sb[r] || (if0.regfile_we_EX && (if0.rd_EX == r) && (if0.rd_data_sel_EX != SEL_ALU));
  endfunction

  task automatic idle0();
    if0.id_valid = 0; if0.rs1_ID = 0; if0.rs2_ID = 0; if0.rs1_used_ID = 0; if0.rs2_used_ID = 0;
    if0.rd_ID = 0; if0.regfile_we_ID = 0; if0.is_load_ID = 0; if0.regfile_we_EX = 0;
    if0.rd_EX = 0; if0.rd_data_sel_EX = SEL_ALU; if0.branch_taken_EX = 0; if0.mem_req_MEMEX = 0;
    if0.mem_ready = 1; if0.load_wb_valid = 0; if0.load_wb_rd = 0;
  endtask

  task automatic idle1();
    if1.id_valid = 0; if1.rs1_ID = 0; if1.rs2_ID = 0; if1.rs1_used_ID = 0; if1.rs2_used_ID = 0;
    if1.rd_ID = 0; if1.regfile_we_ID = 0; if1.is_load_ID = 0; if1.regfile_we_EX = 0;
    if1.rd_EX = 0; if1.rd_data_sel_EX = SEL_ALU; if1.branch_taken_EX = 0; if1.mem_req_MEMEX = 0;
    if1.mem_ready = 1; if1.load_wb_valid = 0; if1.load_wb_rd = 0;
  endtask

  task automatic load_id(input logic [3:0] rd);
    if0.id_valid = 1; if0.regfile_we_ID = 1; if0.is_load_ID = 1; if0.rd_ID = rd;
  endtask

  // One clock of dut0: predict, compare mid-cycle, advance model at the edge.
  task automatic cycle();
    logic mw, haz, fl, s_if, s_id, b_ex, s_back, b_wb;
    logic [15:0] sb_n;
    int left_n;
    logic [1:0] st_n;
    logic [31:0] cnt_n;
    if (!rst_n) begin m_sb = 0; m_left = 0; m_st = S_RUN; m_cnt = 0; end
    {fl, s_if, s_id, b_ex, s_back, b_wb} = '0;
    mw  = if0.mem_req_MEMEX && !if0.mem_ready;
    haz = if0.id_valid &&
          ((if0.rs1_used_ID && if0.rs1_ID != 0 && m_dep(if0.rs1_ID)) ||
           (if0.rs2_used_ID && if0.rs2_ID != 0 && m_dep(if0.rs2_ID)));
    left_n = m_left;
    if (mw) begin s_if = 1; s_id = 1; s_back = 1; b_wb = 1; end
    else if (m_left > 0) begin fl = 1; left_n = m_left - 1; end
    else if (if0.branch_taken_EX) begin fl = 1; left_n = FC0 - 1; end
    else if (haz) begin s_if = 1; s_id = 1; b_ex = 1; end
    st_n = mw ? S_MW : ((left_n > 0) ? S_FL : S_RUN);
    sb_n = m_sb;
    if (if0.load_wb_valid) sb_n[if0.load_wb_rd] = 0;
    if (if0.id_valid && if0.regfile_we_ID && if0.is_load_ID && if0.rd_ID != 0 && !s_id && !fl)
      sb_n[if0.rd_ID] = 1;
    sb_n[0] = 0;
    cnt_n = (s_id && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
    exp_q.push_back({39'd0, m_st, s_if, s_id, b_ex, s_back, b_wb, fl, fl, m_sb});
    exp_q.push_back({32'd0, m_cnt});
    #2;
    chk("ctl", obs_ctl, exp_q.pop_front());
    chk("stall_count", obs_cnt, exp_q.pop_front());
    @(posedge clk);
    if (rst_n) begin m_sb = sb_n; m_left = left_n; m_st = st_n; m_cnt = cnt_n; end
    #1;
  endtask

  initial begin
    idle0(); idle1();
    m_sb = 0; m_left = 0; m_st = S_RUN; m_cnt = 0;
    #1;
    cycle(); cycle();
    chk("rst_sb", {48'd0, if0.scoreboard}, 64'h0);
    chk("rst_state", {62'd0, st0}, {62'd0, S_RUN});
    rst_n = 1;
    cycle();

    // load to x5 then dependent read: stall until writeback, release after
    load_id(4'd5); cycle();
    chk("sb_x5", {48'd0, if0.scoreboard}, 64'h0020);
    idle0(); if0.id_valid = 1; if0.rs1_ID = 5; if0.rs1_used_ID = 1;
    cycle(); cycle();
    if0.load_wb_valid = 1; if0.load_wb_rd = 5; cycle();
    if0.load_wb_valid = 0; cycle();
    chk("sb_x5_clr", {48'd0, if0.scoreboard}, 64'h0);

    // JAL in EX (PC4) blocks one cycle; ALU result forwards freely
    idle0(); if0.regfile_we_EX = 1; if0.rd_EX = 1; if0.rd_data_sel_EX = SEL_PC4;
    if0.id_valid = 1; if0.rs2_ID = 1; if0.rs2_used_ID = 1;
    cycle();
    if0.regfile_we_EX = 0; cycle();
    if0.regfile_we_EX = 1; if0.rd_data_sel_EX = SEL_ALU; cycle();

    // taken branch: two flush cycles
    idle0(); if0.branch_taken_EX = 1; cycle();
    idle0(); cycle(); cycle(); cycle();

    // branch held under a 3-cycle memory wait, flush follows the ready
    if0.branch_taken_EX = 1; if0.mem_req_MEMEX = 1; if0.mem_ready = 0;
    cycle(); cycle(); cycle();
    if0.mem_ready = 1; cycle();
    idle0(); cycle(); cycle();

    // memory wait interrupting a flush; flush resumes afterwards
    if0.branch_taken_EX = 1; cycle();
    idle0(); if0.mem_req_MEMEX = 1; if0.mem_ready = 0; cycle(); cycle();
    if0.mem_ready = 1; cycle();
    idle0(); cycle(); cycle();

    // simultaneous clear and set on x7: set wins; x0 never hazards
    load_id(4'd7); cycle();
    load_id(4'd7); if0.load_wb_valid = 1; if0.load_wb_rd = 7; cycle();
    chk("sb7_set_wins", {63'd0, if0.scoreboard[7]}, 64'd1);
    idle0(); if0.id_valid = 1; if0.rs1_ID = 0; if0.rs1_used_ID = 1; cycle();
    if0.load_wb_valid = 1; if0.load_wb_rd = 7; if0.id_valid = 0; cycle();

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      if0.id_valid        = $urandom_range(0, 1);
      if0.rs1_ID          = 4'($urandom_range(0, 7));
      if0.rs2_ID          = 4'($urandom_range(0, 7));
      if0.rs1_used_ID     = $urandom_range(0, 1);
      if0.rs2_used_ID     = $urandom_range(0, 1);
      if0.rd_ID           = 4'($urandom_range(0, 7));
      if0.regfile_we_ID   = $urandom_range(0, 1);
      if0.is_load_ID      = $urandom_range(0, 1);
      if0.regfile_we_EX   = $urandom_range(0, 1);
      if0.rd_EX           = 4'($urandom_range(0, 7));
      if0.rd_data_sel_EX  = 2'($urandom_range(0, 3));
      if0.branch_taken_EX = ($urandom_range(0, 7) == 0);
      if0.mem_req_MEMEX   = ($urandom_range(0, 3) == 0);
      if0.mem_ready       = ($urandom_range(0, 2) != 0);
      if0.load_wb_valid   = $urandom_range(0, 1);
      if0.load_wb_rd      = 4'($urandom_range(0, 7));
      cycle();
    end

    // reset in the middle of a memory wait with loads outstanding
    idle0(); rst_n = 0; cycle(); rst_n = 1;
    for (int r = 4; r < 8; r++) begin
      load_id(4'(r)); cycle();
    end
    idle0(); if0.mem_req_MEMEX = 1; if0.mem_ready = 0;
    for (int i = 0; i < 9; i++) cycle();
    chk("pre_rst_sb", {48'd0, if0.scoreboard}, 64'h00F0);
    chk("pre_rst_cnt", obs_cnt, 64'd9);
    chk("pre_rst_state", {62'd0, st0}, {62'd0, S_MW});
    idle0(); rst_n = 0; #1;
    chk("async_rst_sb", {48'd0, if0.scoreboard}, 64'h0);
    chk("async_rst_cnt", obs_cnt, 64'd0);
    chk("async_rst_state", {62'd0, st0}, {62'd0, S_RUN});
    cycle();
    rst_n = 1; cycle(); cycle();

    // FLUSH_CYCLES=1 instance: exactly one flush cycle, state stays RUN
    if1.branch_taken_EX = 1; #2;
    chk("fc1_flush_on", {62'd0, if1.flush_IF, if1.flush_ID}, 64'd3);
    @(posedge clk); #1; if1.branch_taken_EX = 0; #2;
    chk("fc1_flush_off", {62'd0, if1.flush_IF, if1.flush_ID}, 64'd0);
    chk("fc1_state", {62'd0, st1}, {62'd0, S_RUN});
    @(posedge clk); #1;
    chk("fc1_idle", {62'd0, if1.flush_IF, if1.flush_ID}, 64'd0);

    if (exp_q.size() != 0) chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
